rc5_sequencer: RTL
==================

# rc5_sequencer

Iterative RC5-32/12 cipher controller that shares a single half-round engine between two requesters. It arbitrates blocks from two 64-bit request ports, sequences the 26 round keys from an external key table, and runs encryption or decryption per block. It sits between the system front end and the 26-entry key store, and replaces the per-direction encrypt/decrypt instances with one time-shared datapath.

## Interface
- `ROUNDS`, 12, number of RC5 rounds; key count `NKEYS = 2*ROUNDS+2` (26) is derived, not overridable.
- `W`, 32, word width; block width is `2*W` (64).
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `in_vld0`, `in_vld1` in 1 each: requester 0/1 has a block.
- `in_rdy0`, `in_rdy1` out 1 each: block accepted this cycle.
- `in_mode0`, `in_mode1` in 1 each: 0 = encrypt, 1 = decrypt.
- `in_data0`, `in_data1` in 64 each: `A = data[31:0]`, `B = data[63:32]`.
- `out_vld` out 1: result valid.
- `out_rdy` in 1: consumer accepts result.
- `out_data` out 64: result, `{B,A}`.
- `out_src` out 1: index of the requester that owns `out_data`.
- `key_addr` out 5: key table index.
- `key_data` in 32: `S[key_addr]`, combinational read, valid in the same cycle.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:** `in_rdyN` is combinational.
  - `in_rdy0 = IDLE & in_vld0 & (!in_vld1 | prio==0)`.
  - `in_rdy1 = IDLE & in_vld1 & (!in_vld0 | prio==1)`.
  - On accept: load A/B/mode/src and clear counter `k`. Set `prio` to the non-granted requester. Go to RUN.
  - No `in_vld`: stay in IDLE.
- **RUN, 26 cycles, `k = 0..25`:** each cycle performs one half-step using `key_data`.
  - Encrypt: `key_addr = k`.
    - k=0: `A += S0`. k=1: `B += S1`.
    - Odd-indexed pair then `A = ((A^B) <<< B) + S[k]` for even k≥2, and `B = ((B^A) <<< A) + S[k]` for odd k≥3.
  - Decrypt: `key_addr = 25-k`, addr a = 25-k.
    - Odd a≥3: `B = ((B - S[a]) >>> A) ^ A`.
    - Even a≥2: `A = ((A - S[a]) >>> B) ^ B`.
    - a=1: `B -= S1`. a=0: `A -= S0`.
  - Rotate amount is the low 5 bits of the other word. Add and subtract are mod 2^32.
  - At k=25 go to DONE.
- **DONE:** `out_vld=1`; `out_data`/`out_src` are stable. When `out_rdy` is high, go to IDLE.
- `key_addr` is 0 outside RUN.
- `prio` changes only on a grant.

## Timing
- Reset values (cycle after `clr` is sampled high):
  - state IDLE, `prio=0`, `k=0`, A=B=0.
  - `out_vld=0`, `out_data=0`, `out_src=0`, `key_addr=0`, `in_rdy0=in_rdy1=0`.
- `clr` wins over every other event. `clr` in RUN or DONE discards the block; no `out_vld` is produced for it.
- Latency: accept at cycle t → RUN in t+1..t+26 → `out_vld` high from t+27.
- Result handshake at cycle u → IDLE at u+1 → next accept earliest at u+1.
- Minimum spacing between accepts is 28 cycles.
- `in_rdyN` is never high outside IDLE; at most one `in_rdy` is high per cycle.
- `out_vld` holds until `out_rdy`. Output fields must not change while `out_vld=1`.
- Both requesters valid continuously: grants alternate 0,1,0,1… starting with 0 after reset.

## Structure
- Shared package `rc5_pkg`:
  - `W`, `ROUNDS`, `NKEYS`.
  - state enum {IDLE, RUN, DONE}.
  - mode constants ENC=0, DEC=1.
  - functions `rotl`/`rotr` (W-bit, 5-bit amount).
- One sub-module, `rc5_half_step`: combinational; inputs mode, k, A, B, key; outputs next A, B. It holds the arithmetic above. The FSM, counter and arbiter stay in `rc5_sequencer`.

## Test plan
- Bench preloads the key table with the RC5 expansion of the all-zero 16-byte key.
- Encrypt 0: requester 0, mode 0, `in_data=64'h0` → `out_data=64'h6D8F4B15_EEDBA521`, `out_src=0`, `out_vld` exactly 27 cycles after accept.
- Decrypt: requester 1, mode 1, `in_data=64'h6D8F4B15_EEDBA521` → `out_data=64'h0`, `out_src=1`. `key_addr` sequence during RUN is 25,24,…,0.
- Contention: both valid from reset, mode 0 data 1 on port 0 and mode 1 data 2 on port 1, `out_rdy=1`.
  - Grants are port0, port1, port0 at 28-cycle spacing.
  - Each result matches the reference model.
- Backpressure: `out_rdy=0` for 10 cycles after `out_vld` → `out_vld`/`out_data` held constant and no `in_rdy`. Accept resumes the cycle after `out_rdy=1`.
- Reset mid-run: `clr=1` at k=12 → next cycle all outputs at reset values and no `out_vld` for the aborted block. A new block afterward completes correctly.
- Random round-trip: 200 random blocks, encrypt then decrypt through alternating ports → each decrypted result equals its original plaintext.

Source files
------------

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared widths, FSM encoding, mode constants and rotate helpers for the RC5 sequencer.
package rc5_pkg;
    localparam int W = 32;
    localparam int ROUNDS = 12;
    localparam int NKEYS = 2 * ROUNDS + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [4:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction
endpackage

// File: rtl/rc5_half_step.sv
// rc5_half_step: one RC5 half-round (encrypt or inverse) selected by mode and step index k.
module rc5_half_step
    import rc5_pkg::*;
(
    input  logic         mode,
    input  logic [4:0]   k,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] key,
    output logic [W-1:0] a_nx,
    output logic [W-1:0] b_nx
);
    logic [4:0]   idx;
    logic [W-1:0] ea, eb, da, db;

    // Decrypt walks the key table backwards; even indices update A, odd update B.
    always_comb begin
        idx  = (mode == DEC) ? 5'(NKEYS - 1) - k : k;
        ea   = (idx == 5'd0) ? a + key : rotl(a ^ b, b[4:0]) + key;
        eb   = (idx == 5'd1) ? b + key : rotl(b ^ a, a[4:0]) + key;
        da   = (idx == 5'd0) ? a - key : rotr(a - key, b[4:0]) ^ b;
        db   = (idx == 5'd1) ? b - key : rotr(b - key, a[4:0]) ^ a;
        a_nx = idx[0] ? a : ((mode == DEC) ? da : ea);
        b_nx = idx[0] ? ((mode == DEC) ? db : eb) : b;
    end
endmodule

// File: rtl/rc5_sequencer.sv
// rc5_sequencer: two-port arbitrated, iterative RC5-32/12 encrypt/decrypt over a shared half-step engine.
module rc5_sequencer
    import rc5_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           in_vld0,
    input  logic           in_vld1,
    output logic           in_rdy0,
    output logic           in_rdy1,
    input  logic           in_mode0,
    input  logic           in_mode1,
    input  logic [2*W-1:0] in_data0,
    input  logic [2*W-1:0] in_data1,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [2*W-1:0] out_data,
    output logic           out_src,
    output logic [4:0]     key_addr,
    input  logic [W-1:0]   key_data
);
    state_t         state_q, state_d;
    logic           prio_q, prio_d, mode_q, mode_d, src_q, src_d;
    logic [4:0]     k_q, k_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, a_nx, b_nx;
    logic [2*W-1:0] in_sel;

    rc5_half_step u_step (
        .mode (mode_q),
        .k    (k_q),
        .a    (a_q),
        .b    (b_q),
        .key  (key_data),
        .a_nx (a_nx),
        .b_nx (b_nx)
    );

    // Ready is suppressed under clr so a requester never sees a grant that reset discards.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        mode_d  = mode_q;
        src_d   = src_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        in_rdy0 = !clr && state_q == IDLE && in_vld0 && (!in_vld1 || !prio_q);
        in_rdy1 = !clr && state_q == IDLE && in_vld1 && (!in_vld0 || prio_q);
        in_sel  = in_rdy1 ? in_data1 : in_data0;
        unique case (state_q)
            IDLE: if (in_rdy0 || in_rdy1) begin
                state_d = RUN;
                prio_d  = in_rdy0;
                src_d   = in_rdy1;
                mode_d  = in_rdy1 ? in_mode1 : in_mode0;
                k_d     = '0;
                a_d     = in_sel[W-1:0];
                b_d     = in_sel[2*W-1:W];
            end
            RUN: begin
                a_d     = a_nx;
                b_d     = b_nx;
                k_d     = k_q + 5'd1;
                state_d = (k_q == 5'(NKEYS - 1)) ? DONE : RUN;
            end
            DONE:    state_d = out_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            mode_q  <= ENC;
            src_q   <= 1'b0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign out_vld  = state_q == DONE;
    assign out_data = {b_q, a_q};
    assign out_src  = src_q;
    assign key_addr = (state_q == RUN) ? ((mode_q == DEC) ? 5'(NKEYS - 1) - k_q : k_q) : 5'd0;
endmodule
